alu_uart_host: RTL and testbench
================================

# alu_uart_host

Host-side initiator for the ALU-over-UART link: accepts one command (opcode, operand A, operand B) on a valid/ready port and serialises it as three bytes into the UART TX FIFO. It then pops the single result byte from the UART RX FIFO and presents it on a valid/ready response port. It sits between a test/control master and the `uart` core on the side of the link opposite the ALU-side interface, and bounds the result wait with a timeout.

## Interface
- `DBIT`, 8, UART data bits per byte
- `NB_OP`, 6, opcode width; requires NB_OP ≤ DBIT
- `NB_AB`, 8, operand/result width; requires NB_AB ≤ DBIT
- `TIMEOUT_CYC`, 1000000, clock cycles to wait for the result byte; requires ≥ 2
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_op`  in  NB_OP  opcode
- `cmd_a`, `cmd_b`  in  NB_AB  operands
- `rsp_valid`  out  1  response held valid
- `rsp_ready`  in  1  response consumed
- `rsp_result`  out  NB_AB  result byte, 0 on timeout
- `rsp_timeout`  out  1  response produced by timeout
- `busy`  out  1  state ≠ IDLE
- `w_data`  out  DBIT  byte to TX FIFO
- `wr_uart`  out  1  push `w_data`, one cycle per byte
- `tx_full`  in  1  TX FIFO full
- `r_data`  in  DBIT  RX FIFO head, valid while `rx_empty`=0
- `rd_uart`  out  1  pop RX FIFO head
- `rx_empty`  in  1  RX FIFO empty

## Operation
- States: IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RES, RESP.
- IDLE:
  - If `rx_empty`=0, drain a stale byte: `rd_uart`=1, data discarded, `cmd_ready`=0.
  - Otherwise `cmd_ready`=1. On `cmd_valid`, capture op/a/b into registers and go to SEND_OP.
- SEND_OP/SEND_A/SEND_B:
  - `w_data` = captured field, zero-extended to DBIT.
  - `wr_uart` = ~`tx_full`, combinational. Advance only when the push happens; hold while `tx_full`=1.
  - SEND_B advances to WAIT_RES.
- WAIT_RES:
  - Timeout counter clears on entry.
  - If `rx_empty`=0: `rd_uart`=1, latch `r_data[NB_AB-1:0]` into the result, clear the timeout flag, go to RESP.
  - Else the counter increments. At count TIMEOUT_CYC-1: result=0, timeout flag=1, go to RESP. No pop.
  - Byte arrival in the same cycle as expiry: the byte wins, not a timeout.
- RESP:
  - `rsp_valid`=1; result and timeout held stable.
  - On `rsp_ready`, go to IDLE.
  - `cmd_ready`=0 throughout.
- `rd_uart` and `wr_uart` are never high together and never high for two consecutive cycles on the same byte.
- Reset (any state, any time): state→IDLE; captured fields, result, timeout flag and counter → 0. Any in-flight command is abandoned. Bytes already pushed are not recalled.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_result`=0, `rsp_timeout`=0, `busy`=0, `wr_uart`=0, `w_data`=0.
  - `rd_uart` = ~`rx_empty`; `cmd_ready` = `rx_empty` (both combinational from IDLE).
- Command accepted at edge 0 with TX never full: `wr_uart` high in cycles 1, 2, 3 carrying op, A, B.
- `rx_empty` falls in WAIT_RES cycle k: `rd_uart` high in cycle k, `rsp_valid` high from cycle k+1.
- Timeout: `rsp_valid` high exactly TIMEOUT_CYC cycles after entering WAIT_RES.
- Back-to-back commands: next `cmd_ready` is the cycle after the `rsp_valid`&`rsp_ready` handshake; minimum 6 cycles per transaction.

## Structure
- Shared package `alu_uart_pkg`:
  - state encoding (3-bit, IDLE=0 … RESP=5);
  - default DBIT/NB_OP/NB_AB constants, also used by the ALU-side interface.
- Sub-module `uart_timeout_timer`:
  - parameter TIMEOUT_CYC, counter width $clog2(TIMEOUT_CYC);
  - inputs `clr`, `en`; output `expired`.
- Remaining FSM, capture registers and output mux live in the top.

## Test plan
- Stale-byte drain: 2 bytes present in RX while IDLE → `rd_uart` pulses twice, `cmd_ready` rises on the third cycle.
- Basic transaction: op=6'h20, A=8'h05, B=8'h03, TX never full → pushes 8'h20, 8'h05, 8'h03 in cycles 1–3. RX supplies 8'h08 → `rsp_result`=8'h08, `rsp_timeout`=0.
- TX backpressure: `tx_full`=1 for 4 cycles during SEND_A → `wr_uart` stays low, A pushed once after release, no byte duplicated or skipped.
- Timeout: TIMEOUT_CYC=16, no RX byte → `rsp_valid` exactly 16 cycles after WAIT_RES entry, result=0, `rsp_timeout`=1, zero pops.
- Byte arriving in the expiry cycle, plus `rsp_ready` held low 5 cycles → result taken, `rsp_timeout`=0, outputs stable until the handshake.
- Reset asserted mid-SEND_B → next cycle `busy`=0, `wr_uart`=0; a fresh command completes normally after release.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared definitions for the ALU-over-UART link: host FSM state
// encoding and default byte/field widths used by both link ends.
package alu_uart_pkg;

    localparam int DBIT_DEF  = 8;
    localparam int NB_OP_DEF = 6;
    localparam int NB_AB_DEF = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_OP  = 3'd1,
        SEND_A   = 3'd2,
        SEND_B   = 3'd3,
        WAIT_RES = 3'd4,
        RESP     = 3'd5
    } state_t;

endpackage

// File: rtl/alu_uart_host_timer.sv
// Result-wait timer: counts enabled cycles from a clear and flags
// the last cycle of the wait window.
module uart_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/alu_uart_host.sv
// Host initiator: serialises op/A/B into the UART TX FIFO, then
// pops one result byte from RX (or times out) and returns it.
module alu_uart_host
    import alu_uart_pkg::*;
#(
    parameter int DBIT        = DBIT_DEF,
    parameter int NB_OP       = NB_OP_DEF,
    parameter int NB_AB       = NB_AB_DEF,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [NB_OP-1:0] cmd_op,
    input  logic [NB_AB-1:0] cmd_a,
    input  logic [NB_AB-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NB_AB-1:0] rsp_result,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [DBIT-1:0]  w_data,
    output logic             wr_uart,
    input  logic             tx_full,
    input  logic [DBIT-1:0]  r_data,
    output logic             rd_uart,
    input  logic             rx_empty
);

    state_t           state;
    state_t           state_nx;
    logic [NB_OP-1:0] op_q;
    logic [NB_AB-1:0] a_q;
    logic [NB_AB-1:0] b_q;
    logic [NB_AB-1:0] res_q;
    logic             to_q;
    logic             expired;
    logic             accept;

    // Stale RX bytes must be drained before a new command is taken.
    assign accept = (state == IDLE) && rx_empty && cmd_valid;

    uart_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (state != WAIT_RES),
        .en     ((state == WAIT_RES) && rx_empty),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (accept)               state_nx = SEND_OP;
            SEND_OP:  if (!tx_full)             state_nx = SEND_A;
            SEND_A:   if (!tx_full)             state_nx = SEND_B;
            SEND_B:   if (!tx_full)             state_nx = WAIT_RES;
            WAIT_RES: if (!rx_empty || expired) state_nx = RESP;
            RESP:     if (rsp_ready)            state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        w_data    = '0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                rd_uart   = ~rx_empty;
                cmd_ready = rx_empty;
            end
            SEND_OP: begin
                wr_uart = ~tx_full;
                w_data  = DBIT'(op_q);
            end
            SEND_A: begin
                wr_uart = ~tx_full;
                w_data  = DBIT'(a_q);
            end
            SEND_B: begin
                wr_uart = ~tx_full;
                w_data  = DBIT'(b_q);
            end
            WAIT_RES: rd_uart   = ~rx_empty;
            RESP:     rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= cmd_op;
                a_q  <= cmd_a;
                b_q  <= cmd_b;
            end
            // A byte arriving in the expiry cycle takes priority.
            if (state == WAIT_RES) begin
                if (!rx_empty) begin
                    res_q <= r_data[NB_AB-1:0];
                    to_q  <= 1'b0;
                end else if (expired) begin
                    res_q <= '0;
                    to_q  <= 1'b1;
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign rsp_result  = res_q;
    assign rsp_timeout = to_q;

endmodule

// File: tb/tb_alu_uart_host.sv
// Self-checking bench for alu_uart_host with TX/RX FIFO models and
// a latency/result reference model derived from the link rules.
module tb_alu_uart_host;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_timeout;
    logic       busy;
    logic [7:0] w_data;
    logic       wr_uart;
    logic       tx_full;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       rx_empty;

    int total = 0;
    int bad = 0;
    int pop_cnt = 0;
    int proto_bad = 0;
    logic [7:0] tx_log[$];
    logic [7:0] rx_q[$];
    logic mon_rd;

    alu_uart_host #(
        .DBIT(8), .NB_OP(6), .NB_AB(8), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .busy(busy), .w_data(w_data), .wr_uart(wr_uart),
        .tx_full(tx_full), .r_data(r_data), .rd_uart(rd_uart),
        .rx_empty(rx_empty)
    );

    always #5 clk = ~clk;

    task automatic upd_rx();
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    endtask

    // TX FIFO log and RX FIFO pop model
    always @(posedge clk) begin
        mon_rd = rd_uart;
        if (reset) begin
            if (wr_uart) tx_log.push_back(w_data);
            if (rd_uart) pop_cnt++;
            if (wr_uart && rd_uart) proto_bad++;
        end
        #1;
        if (mon_rd && rx_q.size() > 0) void'(rx_q.pop_front());
        upd_rx();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic run_cmd(
        input  logic [5:0] op,
        input  logic [7:0] a,
        input  logic [7:0] b,
        input  int         full_cyc,
        input  int         rx_delay,
        input  logic [7:0] rx_byte,
        input  int         rdy_delay,
        output int         lat,
        output logic [7:0] res,
        output logic       to,
        output int         unstable,
        output int         wr_bad,
        output int         cyc_total,
        output int         pops
    );
        int tc, n, pushes, fl, k, base;
        lat = -1; res = 8'h00; to = 1'b0; unstable = 0;
        wr_bad = 0; cyc_total = -1; pops = 0;
        tx_log.delete();
        base = pop_cnt;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        tc = 0; pushes = 0; fl = full_cyc; n = 0;
        while (pushes < 3 && n < 60) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            tx_full = (pushes == 1 && fl > 0);
            #1; tc++; n++;
            if (wr_uart !== !tx_full) wr_bad++;
            if (tx_full) fl--;
            else if (wr_uart) pushes++;
        end
        k = 0;
        while (k < TO + 8) begin
            @(negedge clk);
            tx_full = 1'b0;
            if (k == rx_delay) begin
                rx_q.push_back(rx_byte);
                upd_rx();
            end
            #1; tc++;
            if (rsp_valid) break;
            k++;
        end
        if (!rsp_valid) return;
        lat = k; res = rsp_result; to = rsp_timeout;
        for (int h = 0; h < rdy_delay; h++) begin
            @(negedge clk); #1; tc++;
            if (rsp_valid !== 1'b1 || rsp_result !== res ||
                rsp_timeout !== to) unstable++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1; tc++;
        if (cmd_ready && !busy) cyc_total = tc;
        pops = pop_cnt - base;
    endtask

    task automatic test_reset();
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++;
            $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
        total++; if (rsp_result !== 8'h00) begin bad++;
            $display("FAIL rst_result got %0h want 0", rsp_result); end
        total++; if (rsp_timeout !== 1'b0) begin bad++;
            $display("FAIL rst_timeout got %0b want 0", rsp_timeout); end
        total++; if (busy !== 1'b0) begin bad++;
            $display("FAIL rst_busy got %0b want 0", busy); end
        total++; if (wr_uart !== 1'b0) begin bad++;
            $display("FAIL rst_wr_uart got %0b want 0", wr_uart); end
        total++; if (w_data !== 8'h00) begin bad++;
            $display("FAIL rst_w_data got %0h want 0", w_data); end
        total++; if (rd_uart !== 1'b0) begin bad++;
            $display("FAIL rst_rd_uart got %0b want 0", rd_uart); end
        total++; if (cmd_ready !== 1'b1) begin bad++;
            $display("FAIL rst_cmd_ready got %0b want 1", cmd_ready); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_drain();
        int base;
        logic exp_rd, exp_rdy;
        base = pop_cnt;
        @(negedge clk);
        rx_q.push_back(8'hDE);
        rx_q.push_back(8'hAD);
        upd_rx();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_rd  = (c < 2);
            exp_rdy = (c == 2);
            total++; if (rd_uart !== exp_rd) begin bad++;
                $display("FAIL drain_rd c%0d got %0b want %0b",
                         c, rd_uart, exp_rd); end
            total++; if (cmd_ready !== exp_rdy) begin bad++;
                $display("FAIL drain_ready c%0d got %0b want %0b",
                         c, cmd_ready, exp_rdy); end
        end
        total++; if (pop_cnt - base !== 2) begin bad++;
            $display("FAIL drain_pops got %0d want 2", pop_cnt - base); end
    endtask

    task automatic test_basic();
        int lat, uns, wb, tc, pops;
        logic [7:0] res;
        logic to;
        run_cmd(6'h20, 8'h05, 8'h03, 0, 0, 8'h08, 0,
                lat, res, to, uns, wb, tc, pops);
        total++; if (tx_log.size() !== 3) begin bad++;
            $display("FAIL basic_nbytes got %0d want 3", tx_log.size()); end
        else begin
            total++; if (tx_log[0] !== 8'h20 || tx_log[1] !== 8'h05 ||
                         tx_log[2] !== 8'h03) begin bad++;
                $display("FAIL basic_bytes got %h %h %h want 20 05 03",
                         tx_log[0], tx_log[1], tx_log[2]); end
        end
        total++; if (wb !== 0) begin bad++;
            $display("FAIL basic_wr_timing got %0d want 0", wb); end
        total++; if (res !== 8'h08 || to !== 1'b0) begin bad++;
            $display("FAIL basic_result got %h/%b want 08/0", res, to); end
        total++; if (lat !== 1) begin bad++;
            $display("FAIL basic_latency got %0d want 1", lat); end
        total++; if (pops !== 1) begin bad++;
            $display("FAIL basic_pops got %0d want 1", pops); end
    endtask

    task automatic test_backpressure();
        int lat, uns, wb, tc, pops;
        logic [7:0] res;
        logic to;
        run_cmd(6'h11, 8'hC3, 8'h5A, 4, 2, 8'h77, 0,
                lat, res, to, uns, wb, tc, pops);
        total++; if (wb !== 0) begin bad++;
            $display("FAIL bp_wr_vs_full got %0d want 0", wb); end
        total++; if (tx_log.size() !== 3) begin bad++;
            $display("FAIL bp_nbytes got %0d want 3", tx_log.size()); end
        else begin
            total++; if (tx_log[0] !== 8'h11 || tx_log[1] !== 8'hC3 ||
                         tx_log[2] !== 8'h5A) begin bad++;
                $display("FAIL bp_bytes got %h %h %h want 11 c3 5a",
                         tx_log[0], tx_log[1], tx_log[2]); end
        end
        total++; if (tc !== 5 + 4 + 3 + 0) begin bad++;
            $display("FAIL bp_cycles got %0d want 12", tc); end
    endtask

    task automatic test_timeout();
        int lat, uns, wb, tc, pops;
        logic [7:0] res;
        logic to;
        run_cmd(6'h3F, 8'hFF, 8'hFF, 0, -1, 8'h00, 0,
                lat, res, to, uns, wb, tc, pops);
        total++; if (lat !== TO) begin bad++;
            $display("FAIL to_latency got %0d want %0d", lat, TO); end
        total++; if (res !== 8'h00 || to !== 1'b1) begin bad++;
            $display("FAIL to_result got %h/%b want 00/1", res, to); end
        total++; if (pops !== 0) begin bad++;
            $display("FAIL to_pops got %0d want 0", pops); end
    endtask

    task automatic test_expiry_byte();
        int lat, uns, wb, tc, pops;
        logic [7:0] res;
        logic to;
        run_cmd(6'h01, 8'h10, 8'h20, 0, TO - 1, 8'hA5, 5,
                lat, res, to, uns, wb, tc, pops);
        total++; if (lat !== TO) begin bad++;
            $display("FAIL exp_latency got %0d want %0d", lat, TO); end
        total++; if (res !== 8'hA5 || to !== 1'b0) begin bad++;
            $display("FAIL exp_result got %h/%b want a5/0", res, to); end
        total++; if (uns !== 0) begin bad++;
            $display("FAIL exp_stable got %0d want 0", uns); end
        total++; if (pops !== 1) begin bad++;
            $display("FAIL exp_pops got %0d want 1", pops); end
        total++; if (tc !== 5 + TO + 5) begin bad++;
            $display("FAIL exp_cycles got %0d want %0d", tc, 5 + TO + 5); end
    endtask

    task automatic test_reset_mid();
        int lat, uns, wb, tc, pops, pushes, n;
        logic [7:0] res;
        logic to;
        tx_log.delete();
        @(negedge clk);
        cmd_op = 6'h2A; cmd_a = 8'h99; cmd_b = 8'h66; cmd_valid = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++;
            $display("FAIL rm_ready got %0b want 1", cmd_ready); end
        pushes = 0; n = 0;
        while (pushes < 2 && n < 20) begin
            @(negedge clk); cmd_valid = 1'b0; #1; n++;
            if (wr_uart) pushes++;
        end
        @(negedge clk); #1;
        total++; if (wr_uart !== 1'b1 || w_data !== 8'h66) begin bad++;
            $display("FAIL rm_send_b got %b/%h want 1/66", wr_uart, w_data); end
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || wr_uart !== 1'b0) begin bad++;
            $display("FAIL rm_reset got busy=%b wr=%b want 0/0",
                     busy, wr_uart); end
        @(negedge clk);
        total++; if (tx_log.size() !== 2) begin bad++;
            $display("FAIL rm_nbytes got %0d want 2", tx_log.size()); end
        reset = 1'b1;
        run_cmd(6'h07, 8'h44, 8'h33, 0, 3, 8'h5C, 1,
                lat, res, to, uns, wb, tc, pops);
        total++; if (res !== 8'h5C || to !== 1'b0 || lat !== 4) begin bad++;
            $display("FAIL rm_fresh got %h/%b lat %0d want 5c/0 lat 4",
                     res, to, lat); end
    endtask

    task automatic test_back_to_back();
        int lat, uns, wb, tc, pops;
        logic [7:0] res;
        logic [7:0] byt;
        logic to;
        for (int i = 0; i < 3; i++) begin
            byt = 8'($urandom);
            run_cmd(6'($urandom), 8'($urandom), 8'($urandom), 0, 0, byt, 0,
                    lat, res, to, uns, wb, tc, pops);
            total++; if (tc !== 6) begin bad++;
                $display("FAIL b2b_cycles i%0d got %0d want 6", i, tc); end
            total++; if (res !== byt || to !== 1'b0) begin bad++;
                $display("FAIL b2b_result i%0d got %h/%b want %h/0",
                         i, res, to, byt); end
        end
    endtask

    task automatic test_random();
        int lat, uns, wb, tc, pops;
        int full, rxd, rdy, el, ep, et;
        logic [5:0] op;
        logic [7:0] a, b, byt, res, eres;
        logic to, eto, hit;
        for (int i = 0; i < 16; i++) begin
            op = 6'($urandom); a = 8'($urandom); b = 8'($urandom);
            byt = 8'($urandom);
            full = $urandom_range(0, 3);
            rxd = $urandom_range(0, TO + 3);
            if (rxd >= TO) rxd = -1;
            rdy = $urandom_range(0, 3);
            hit  = (rxd >= 0);
            el   = hit ? rxd + 1 : TO;
            eres = hit ? byt : 8'h00;
            eto  = !hit;
            ep   = hit ? 1 : 0;
            et   = 5 + full + el + rdy;
            run_cmd(op, a, b, full, rxd, byt, rdy,
                    lat, res, to, uns, wb, tc, pops);
            total++; if (tx_log.size() !== 3) begin bad++;
                $display("FAIL rnd_nbytes i%0d got %0d want 3",
                         i, tx_log.size()); end
            else begin
                total++; if (tx_log[0] !== {2'b00, op} || tx_log[1] !== a ||
                             tx_log[2] !== b) begin bad++;
                    $display("FAIL rnd_bytes i%0d got %h %h %h want %h %h %h",
                             i, tx_log[0], tx_log[1], tx_log[2],
                             {2'b00, op}, a, b); end
            end
            total++; if (lat !== el) begin bad++;
                $display("FAIL rnd_latency i%0d got %0d want %0d", i, lat, el); end
            total++; if (res !== eres || to !== eto) begin bad++;
                $display("FAIL rnd_result i%0d got %h/%b want %h/%b",
                         i, res, to, eres, eto); end
            total++; if (pops !== ep || uns !== 0 || wb !== 0) begin bad++;
                $display("FAIL rnd_misc i%0d got pops=%0d uns=%0d wb=%0d want %0d/0/0",
                         i, pops, uns, wb, ep); end
            total++; if (tc !== et) begin bad++;
                $display("FAIL rnd_cycles i%0d got %0d want %0d", i, tc, et); end
        end
    endtask

    task automatic test_protocol();
        total++; if (proto_bad !== 0) begin bad++;
            $display("FAIL proto_rd_wr got %0d want 0", proto_bad); end
    endtask

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0; tx_full = 1'b0;
        upd_rx();
        test_reset();
        test_drain();
        test_basic();
        test_backpressure();
        test_timeout();
        test_expiry_byte();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
